// File: rtl/echo_noc_pkg.sv
// Shared types for the echo request path: the NOCDataH beat, header field
// positions and the request funnel state encoding.
package echo_noc_pkg;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  length;
    } NOCDataH;

    localparam int HDR_METHOD_MSB = 31;
    localparam int HDR_METHOD_LSB = 16;
    localparam int HDR_LEN_MSB    = 15;
    localparam int HDR_LEN_LSB    = 0;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        SEND,
        DISCARD
    } funnel_state_e;

endpackage

// File: rtl/echo_req_funnel.sv
// Packs framed 32-bit host words into one NOCDataH beat for the echo request pipe.
// Optional frame/drop counters are built when ECHO_FUNNEL_STATS_EN is defined.
module echo_req_funnel
   import echo_noc_pkg::*;
#(
   parameter int MAX_WORDS = 4
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         in_enq__ENA,
   input  logic [31:0]  in_enq_v,
   output logic         in_enq__RDY,
   output logic         out_enq__ENA,
   output logic [143:0] out_enq_v,
   input  logic         out_enq__RDY
`ifdef ECHO_FUNNEL_STATS_EN
   ,
   output logic [31:0]  stat_frames,
   output logic [31:0]  stat_drops
`endif
);

   localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

   funnel_state_e state, next_state;
   logic [15:0]   remaining;
   logic [1:0]    slot;
   NOCDataH       beat;

   logic          accept;
   logic          transfer;
   logic [15:0]   hdr_len;
   logic [15:0]   eff_len;
   logic [15:0]   hdr_method;

   assign hdr_method = in_enq_v[HDR_METHOD_MSB:HDR_METHOD_LSB];
   assign hdr_len    = in_enq_v[HDR_LEN_MSB:HDR_LEN_LSB];
   // A zero length is a header-only frame.
   assign eff_len    = (hdr_len == 16'd0) ? 16'd1 : hdr_len;

   assign in_enq__RDY  = nRST && (state != SEND);
   assign accept       = in_enq__ENA && in_enq__RDY;
   assign out_enq__ENA = nRST && (state == SEND) && out_enq__RDY;
   assign transfer     = out_enq__ENA;
   assign out_enq_v    = beat;

   // Next-state selection for the framing FSM.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (eff_len == 16'd1) begin
                  next_state = SEND;
               end else if (eff_len <= MAX_LEN) begin
                  next_state = COLLECT;
               end else begin
                  next_state = DISCARD;
               end
            end
         end
         COLLECT: begin
            if (accept && remaining == 16'd1) begin
               next_state = SEND;
            end
         end
         DISCARD: begin
            if (accept && remaining == 16'd1) begin
               next_state = IDLE;
            end
         end
         SEND: begin
            if (transfer) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State register, word counter and beat assembly.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state     <= IDLE;
         remaining <= '0;
         slot      <= '0;
         beat      <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && accept) begin
            remaining   <= eff_len - 16'd1;
            slot        <= '0;
            beat.data   <= {hdr_method, 112'b0};
            beat.length <= eff_len;
         end else if (state == COLLECT && accept) begin
            remaining <= remaining - 16'd1;
            slot      <= slot + 2'd1;
            // Payload slots fill from the top of the data field downward.
            case (slot)
               2'd0:    beat.data[111:80] <= in_enq_v;
               2'd1:    beat.data[79:48]  <= in_enq_v;
               default: beat.data[47:16]  <= in_enq_v;
            endcase
         end else if (state == DISCARD && accept) begin
            remaining <= remaining - 16'd1;
         end
      end
   end

`ifdef ECHO_FUNNEL_STATS_EN
   logic frame_done;
   logic frame_drop;

   assign frame_done = transfer;
   assign frame_drop = (state == DISCARD) && accept && (remaining == 16'd1);

   // Forwarded and dropped frame counters.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         stat_frames <= '0;
         stat_drops  <= '0;
      end else begin
         if (frame_done) stat_frames <= stat_frames + 32'd1;
         if (frame_drop) stat_drops  <= stat_drops + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_echo_req_funnel.sv
// Self-checking bench for echo_req_funnel; expected beats come from a
// frame-level model built from the header/payload rules.
module tb_echo_req_funnel;

   logic         CLK = 1'b0;
   logic         nRST = 1'b0;
   logic         in_ena = 1'b0;
   logic [31:0]  in_v = '0;
   logic         in_rdy;
   logic         out_ena;
   logic [143:0] out_v;
   logic         out_rdy = 1'b0;
`ifdef ECHO_FUNNEL_STATS_EN
   logic [31:0]  stat_frames;
   logic [31:0]  stat_drops;
`endif

   int passed = 0;
   int total = 0;
   int exp_frames = 0;
   int exp_drops = 0;

   echo_req_funnel #(.MAX_WORDS(4)) dut (
      .CLK(CLK),
      .nRST(nRST),
      .in_enq__ENA(in_ena),
      .in_enq_v(in_v),
      .in_enq__RDY(in_rdy),
      .out_enq__ENA(out_ena),
      .out_enq_v(out_v),
      .out_enq__RDY(out_rdy)
`ifdef ECHO_FUNNEL_STATS_EN
      ,
      .stat_frames(stat_frames),
      .stat_drops(stat_drops)
`endif
   );

   always #5 CLK = ~CLK;

   // Expected beat for a well-formed frame (header plus any payload words).
   function automatic logic [143:0] model_beat(input logic [31:0] frame[$]);
      int len;
      logic [31:0] p [3];
      len = (frame[0][15:0] == 16'd0) ? 1 : int'(frame[0][15:0]);
      for (int i = 0; i < 3; i++) begin
         p[i] = (i + 1 < len && i + 1 < frame.size()) ? frame[i + 1] : 32'h0;
      end
      return {frame[0][31:16], p[0], p[1], p[2], 16'h0, 16'(len)};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w);
      in_ena = 1'b1;
      in_v   = w;
      tick();
      in_ena = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] frame[$]);
      foreach (frame[i]) send_word(frame[i]);
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      in_ena = 1'b0;
      out_rdy = 1'b1;
      repeat (3) tick();
      @(negedge CLK);
      total++;
      if (in_rdy !== 1'b0 || out_ena !== 1'b0 || out_v !== 144'h0)
         $display("[TB] FAIL reset_hold: rdy=%b ena=%b v=%h required 0/0/0", in_rdy, out_ena, out_v);
      else passed++;
      tick();
      nRST = 1'b1;
      @(negedge CLK);
      total++;
      if (in_rdy !== 1'b1 || out_ena !== 1'b0 || out_v !== 144'h0)
         $display("[TB] FAIL reset_release: rdy=%b ena=%b v=%h required 1/0/0", in_rdy, out_ena, out_v);
      else passed++;
`ifdef ECHO_FUNNEL_STATS_EN
      total++;
      if (stat_frames !== 32'd0 || stat_drops !== 32'd0)
         $display("[TB] FAIL reset_stats: frames=%0d drops=%0d required 0/0", stat_frames, stat_drops);
      else passed++;
`endif
      exp_frames = 0;
      exp_drops = 0;
      tick();
   endtask

   task automatic test_single();
      logic [31:0] frame[$];
      frame = '{32'h0000_0002, 32'hDEAD_BEEF};
      out_rdy = 1'b1;
      send_frame(frame);
      @(negedge CLK);
      total++;
      if (out_ena !== 1'b1 || out_v !== model_beat(frame))
         $display("[TB] FAIL single_beat: ena=%b v=%h required 1 %h", out_ena, out_v, model_beat(frame));
      else passed++;
      total++;
      if (out_v[127:96] !== 32'hDEAD_BEEF || out_v[15:0] !== 16'd2)
         $display("[TB] FAIL single_fields: p1=%h len=%h required deadbeef 2", out_v[127:96], out_v[15:0]);
      else passed++;
      exp_frames++;
      tick();
      @(negedge CLK);
      total++;
      if (out_ena !== 1'b0 || in_rdy !== 1'b1)
         $display("[TB] FAIL single_after: ena=%b rdy=%b required 0 1", out_ena, in_rdy);
      else passed++;
   endtask

   task automatic test_len0();
      logic [31:0] frame[$];
      frame = '{32'h0003_0000};
      out_rdy = 1'b1;
      send_frame(frame);
      @(negedge CLK);
      total++;
      if (out_ena !== 1'b1 || out_v !== {16'h3, 96'h0, 16'h0, 16'h1})
         $display("[TB] FAIL len0_beat: ena=%b v=%h required 1 %h", out_ena, out_v, {16'h3, 96'h0, 16'h0, 16'h1});
      else passed++;
      exp_frames++;
      tick();
   endtask

   task automatic test_oversize();
      logic [31:0] frame[$];
      int seen = 0;
      out_rdy = 1'b1;
      send_word(32'h0000_0007);
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         if (out_ena === 1'b1) seen++;
         send_word($urandom);
      end
      @(negedge CLK);
      if (out_ena === 1'b1) seen++;
      total++;
      if (seen != 0 || in_rdy !== 1'b1)
         $display("[TB] FAIL oversize_dropped: beats=%0d rdy=%b required 0 1", seen, in_rdy);
      else passed++;
      exp_drops++;
`ifdef ECHO_FUNNEL_STATS_EN
      total++;
      if (stat_drops !== 32'(exp_drops))
         $display("[TB] FAIL oversize_drops: got %0d required %0d", stat_drops, exp_drops);
      else passed++;
`endif
      frame = '{32'h0009_0004, $urandom, $urandom, $urandom};
      send_frame(frame);
      @(negedge CLK);
      total++;
      if (out_ena !== 1'b1 || out_v !== model_beat(frame))
         $display("[TB] FAIL oversize_next: ena=%b v=%h required 1 %h", out_ena, out_v, model_beat(frame));
      else passed++;
      exp_frames++;
      tick();
   endtask

   task automatic test_backpressure();
      logic [31:0] frame[$];
      int bad = 0;
      frame = '{{16'($urandom), 16'd4}, $urandom, $urandom, $urandom};
      out_rdy = 1'b0;
      send_frame(frame);
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (in_rdy !== 1'b0 || out_ena !== 1'b0 || out_v !== model_beat(frame)) bad++;
         tick();
      end
      total++;
      if (bad != 0)
         $display("[TB] FAIL bp_hold: %0d bad cycles, required 0", bad);
      else passed++;
      out_rdy = 1'b1;
      @(negedge CLK);
      total++;
      if (out_ena !== 1'b1 || out_v !== model_beat(frame))
         $display("[TB] FAIL bp_release: ena=%b v=%h required 1 %h", out_ena, out_v, model_beat(frame));
      else passed++;
      exp_frames++;
      tick();
      @(negedge CLK);
      total++;
      if (out_ena !== 1'b0)
         $display("[TB] FAIL bp_single: ena=%b required 0", out_ena);
      else passed++;
      tick();
   endtask

   task automatic test_reset_midframe();
      logic [31:0] frame[$];
      out_rdy = 1'b1;
      send_word(32'h0004_0004);
      send_word(32'hAAAA_5555);
      send_word(32'h1234_5678);
      nRST = 1'b0;
      tick();
      nRST = 1'b1;
      exp_frames = 0;
      exp_drops = 0;
      @(negedge CLK);
      total++;
      if (out_ena !== 1'b0 || in_rdy !== 1'b1 || out_v !== 144'h0)
         $display("[TB] FAIL midreset_idle: ena=%b rdy=%b v=%h required 0 1 0", out_ena, in_rdy, out_v);
      else passed++;
      frame = '{32'h0005_0002, 32'hCAFE_F00D};
      send_frame(frame);
      @(negedge CLK);
      total++;
      if (out_ena !== 1'b1 || out_v !== model_beat(frame))
         $display("[TB] FAIL midreset_next: ena=%b v=%h required 1 %h", out_ena, out_v, model_beat(frame));
      else passed++;
      exp_frames++;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0]  words[$];
      logic [143:0] exp_q[$];
      logic [143:0] e;
      logic [31:0]  frame[$];
      logic [31:0]  junk;
      int bad = 0;
      int got = 0;
      for (int f = 0; f < 100; f++) begin
         int len;
         len = $urandom_range(1, 4);
         frame = '{};
         frame.push_back({16'($urandom), 16'(len)});
         for (int i = 1; i < len; i++) frame.push_back($urandom);
         foreach (frame[i]) words.push_back(frame[i]);
         exp_q.push_back(model_beat(frame));
      end
      for (int cyc = 0; cyc < 5000 && (words.size() > 0 || exp_q.size() > 0); cyc++) begin
         in_ena  = (words.size() > 0) && in_rdy && ($urandom_range(3) != 0);
         in_v    = (words.size() > 0) ? words[0] : 32'h0;
         out_rdy = ($urandom_range(2) != 0);
         @(negedge CLK);
         if (in_ena) junk = words.pop_front();
         if (out_ena === 1'b1) begin
            got++;
            if (exp_q.size() == 0 || out_rdy !== 1'b1) begin
               bad++;
            end else begin
               e = exp_q.pop_front();
               if (out_v !== e) begin
                  bad++;
                  $display("[TB] FAIL b2b_beat: got %h required %h", out_v, e);
               end
            end
         end
         tick();
      end
      in_ena = 1'b0;
      out_rdy = 1'b1;
      total++;
      if (bad != 0 || got != 100 || words.size() != 0 || exp_q.size() != 0)
         $display("[TB] FAIL b2b_summary: bad=%0d beats=%0d left=%0d required 0 100 0", bad, got, exp_q.size());
      else passed++;
      exp_frames += 100;
`ifdef ECHO_FUNNEL_STATS_EN
      @(negedge CLK);
      total++;
      if (stat_frames !== 32'(exp_frames))
         $display("[TB] FAIL b2b_frames: got %0d required %0d", stat_frames, exp_frames);
      else passed++;
      tick();
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_len0();
      test_oversize();
      test_backpressure();
      test_reset_midframe();
      test_back_to_back();
      $display("[TB] %0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
